seq_restoring_divider: RTL and testbench

- Sequential unsigned restoring divider. Performs one shift-and-subtract step per clock.
- Each step uses a single two's-complement subtractor: A - B computed as A + (~B) + 1, with a sign/borrow bit above the operand width.
- Single-issue unit with a start/busy/done handshake. Sits beside the small-width arithmetic blocks and is the controller that sequences the shared subtract datapath over W iterations.

---
 rtl/seq_restoring_divider.sv | 125 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential unsigned restoring divider, one subtract step per clock
// Optional DIV_ZERO_TRAP_EN: zero divisor skips the iterations and raises div_by_zero.
module seq_restoring_divider #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic         div_by_zero
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   q;
  logic [W-1:0]   d;
  logic [W:0]     r;
  logic [CW-1:0]  cnt;

  logic [W:0]     rs;
  logic [W+1:0]   diff;
  logic [W:0]     r_step;
  logic [W-1:0]   q_step;
  logic           accept;
  logic           last_step;
  logic           zero_trap;

  assign accept    = start && (state != S_RUN);
  assign last_step = (state == S_RUN) && (cnt == CW'(1));

`ifdef DIV_ZERO_TRAP_EN
  assign zero_trap = (divisor == '0);
`else
  assign zero_trap = 1'b0;
`endif

  // One shared subtractor: the borrow lands in diff[W+1] and selects restore.
  always_comb begin
    rs     = {r[W-1:0], q[W-1]};
    diff   = {1'b0, rs} + ~{2'b00, d} + {{(W+1){1'b0}}, 1'b1};
    r_step = rs;
    q_step = {q[W-2:0], 1'b0};
    if (!diff[W+1]) begin
      r_step = diff[W:0];
      q_step = {q[W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = zero_trap ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = zero_trap ? S_DONE : S_RUN;
        else       state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      d         <= '0;
      r         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_TRAP_EN
      div_by_zero <= 1'b0;
`endif
    end else if (accept) begin
      q   <= dividend;
      d   <= divisor;
      r   <= '0;
      cnt <= CW'(W);
`ifdef DIV_ZERO_TRAP_EN
      div_by_zero <= zero_trap;
      if (zero_trap) begin
        quotient  <= '1;
        remainder <= dividend;
      end
`endif
    end else if (state == S_RUN) begin
      q   <= q_step;
      r   <= r_step;
      cnt <= cnt - CW'(1);
      if (last_step) begin
        quotient  <= q_step;
        remainder <= r_step[W-1:0];
      end
    end
  end

  // A finished partial remainder is always below 2^W, so its top bit must be clear.
  always_ff @(posedge clk) begin
    if (!rst && state == S_DONE) assert (r[W] == 1'b0);
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - randomized and directed checks of seq_restoring_divider against an arithmetic model
module tb_seq_restoring_divider;

  localparam int W = 4;
`ifdef DIV_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef DIV_ZERO_TRAP_EN
  logic         div_by_zero;
`endif

  int vectors = 0;
  int errors  = 0;

  seq_restoring_divider #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_TRAP_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_q(input int a, input int b);
    return (b == 0) ? (1 << W) - 1 : a / b;
  endfunction

  function automatic int model_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic int model_lat(input int b);
    return (TRAP && b == 0) ? 1 : W + 1;
  endfunction

  // Drives one start and waits for done; lat stays 0 if done never arrives.
  task automatic issue(input int a, input int b, output int lat, output int gq,
                       output int gr, output int busy_gaps);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    tick();
    start     = 1'b0;
    lat       = 0;
    gq        = -1;
    gr        = -1;
    busy_gaps = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        lat = c;
        gq  = int'(quotient);
        gr  = int'(remainder);
        break;
      end
      if (!busy) busy_gaps++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient got=%0d exp=0", quotient); end
    vectors++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder got=%0d exp=0", remainder); end
`ifdef DIV_ZERO_TRAP_EN
    vectors++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, gq, gr, gaps;
    issue(13, 3, lat, gq, gr, gaps);
    vectors++; if (lat != 5) begin errors++; $display("FAIL basic_latency got=%0d exp=5", lat); end
    vectors++; if (gaps != 0) begin errors++; $display("FAIL basic_busy got=%0d idle cycles exp=0", gaps); end
    vectors++; if (gq != 4) begin errors++; $display("FAIL basic_quotient got=%0d exp=4", gq); end
    vectors++; if (gr != 1) begin errors++; $display("FAIL basic_remainder got=%0d exp=1", gr); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
    tick();
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    vectors++; if (quotient !== 4'd4) begin errors++; $display("FAIL basic_hold got=%0d exp=4", quotient); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, gq, gr, gaps;
    issue(15, 1, lat, gq, gr, gaps);
    vectors++; if (lat != 5 || gq != 15 || gr != 0) begin
      errors++; $display("FAIL b2b_first got=lat%0d q%0d r%0d exp=lat5 q15 r0", lat, gq, gr); end
    issue(2, 9, lat, gq, gr, gaps);
    vectors++; if (lat != 5) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=5", lat); end
    vectors++; if (gaps != 0) begin errors++; $display("FAIL b2b_idle_gap got=%0d exp=0", gaps); end
    vectors++; if (gq != 0 || gr != 2) begin errors++; $display("FAIL b2b_second got=q%0d r%0d exp=q0 r2", gq, gr); end
    tick();
  endtask

  task automatic test_div_zero();
    int lat, gq, gr, gaps;
    issue(7, 0, lat, gq, gr, gaps);
    vectors++; if (lat != model_lat(0)) begin errors++; $display("FAIL dz_latency got=%0d exp=%0d", lat, model_lat(0)); end
    vectors++; if (gq != 15 || gr != 7) begin errors++; $display("FAIL dz_result got=q%0d r%0d exp=q15 r7", gq, gr); end
`ifdef DIV_ZERO_TRAP_EN
    vectors++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b exp=1", div_by_zero); end
    tick();
    vectors++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag_hold got=%b exp=1", div_by_zero); end
`else
    tick();
`endif
    issue(5, 2, lat, gq, gr, gaps);
    vectors++; if (gq != 2 || gr != 1) begin errors++; $display("FAIL dz_next got=q%0d r%0d exp=q2 r1", gq, gr); end
`ifdef DIV_ZERO_TRAP_EN
    vectors++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_flag_clear got=%b exp=0", div_by_zero); end
`endif
    tick();
  endtask

  task automatic test_ignore_start();
    int lat, extra;
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    dividend = 4'd9; divisor = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    for (int c = 3; c <= 20; c++) begin
      if (done) begin lat = c; break; end
      tick();
    end
    vectors++; if (lat != 5) begin errors++; $display("FAIL ign_latency got=%0d exp=5", lat); end
    vectors++; if (quotient !== 4'd4 || remainder !== 4'd1) begin
      errors++; $display("FAIL ign_result got=q%0d r%0d exp=q4 r1", quotient, remainder); end
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done) extra++;
    end
    vectors++; if (extra != 0) begin errors++; $display("FAIL ign_second_done got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid_run();
    int lat, gq, gr, gaps, extra;
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags got=busy%b done%b exp=busy0 done0", busy, done); end
    vectors++; if (quotient !== '0 || remainder !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got=q%0d r%0d exp=q0 r0", quotient, remainder); end
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done || busy) extra++;
    end
    vectors++; if (extra != 0) begin errors++; $display("FAIL rst_mid_idle got=%0d active cycles exp=0", extra); end
    issue(9, 2, lat, gq, gr, gaps);
    vectors++; if (lat != 5 || gq != 4 || gr != 1) begin
      errors++; $display("FAIL rst_mid_after got=lat%0d q%0d r%0d exp=lat5 q4 r1", lat, gq, gr); end
    tick();
  endtask

  task automatic test_random();
    int a, b, lat, gq, gr, gaps;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      b = int'($urandom_range(0, (1 << W) - 1));
      issue(a, b, lat, gq, gr, gaps);
      vectors++;
      if (lat != model_lat(b) || gq != model_q(a, b) || gr != model_r(a, b)) begin
        errors++;
        $display("FAIL rand %0d/%0d got=lat%0d q%0d r%0d exp=lat%0d q%0d r%0d",
                 a, b, lat, gq, gr, model_lat(b), model_q(a, b), model_r(a, b));
      end
      // Half the time chain the next start straight off the done cycle.
      if ($urandom_range(0, 1) == 0) tick();
    end
    tick();
  endtask

  task automatic test_sweep();
    int lat, gq, gr, gaps;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 1; b < (1 << W); b++) begin
        issue(a, b, lat, gq, gr, gaps);
        vectors++;
        if (lat != W + 1 || gq != a / b || gr != a % b) begin
          errors++;
          $display("FAIL sweep %0d/%0d got=lat%0d q%0d r%0d exp=lat%0d q%0d r%0d",
                   a, b, lat, gq, gr, W + 1, a / b, a % b);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin errors++; $display("FAIL sweep_pulse %0d/%0d got=%b exp=0", a, b, done); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_random();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
